// File: rtl/key_hex_entry.sv
// Keystroke entry engine: key events are buffered in a FIFO and consumed by a
// three-state FSM that builds a hex number (hex mode) or shows the raw event.

module key_hex_entry #(
    parameter int DIGITS     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            key_data,
    input  logic                  key_broken,
    input  logic                  key_data_stb,
    input  logic                  mode,
    input  logic                  clear_overflow,
    output logic [4*DIGITS-1:0]   display_value,
    output logic [3:0]            digit_count,
    output logic [4*DIGITS-1:0]   commit_value,
    output logic                  commit_stb,
    output logic                  overflow,
    output logic [LVL_W-1:0]      fifo_level
);

    localparam int DISP_W = 4 * DIGITS;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0]       CNT_MAX   = 4'(DIGITS);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_EMPTY = {LVL_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    // Returns {valid, nibble} for ASCII 0-9, A-F, a-f.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, c[3:0]};
        end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            r = {1'b1, c[3:0] + 4'd9};
        end else begin
            r = 5'd0;
        end
        return r;
    endfunction

    state_t              state_r;
    state_t              next_state_s;
    logic [8:0]          mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [8:0]          pop_data_r;
    logic [8:0]          entry_r;
    logic [DISP_W-1:0]   acc_r;
    logic                full_s;
    logic                pop_s;
    logic                push_s;
    logic                drop_s;
    logic [4:0]          hex_s;
    logic [DISP_W-1:0]   acc_next_s;
    logic [DISP_W-1:0]   disp_next_s;
    logic [DISP_W-1:0]   commit_next_s;
    logic [3:0]          cnt_next_s;
    logic                commit_fire_s;

    // FIFO handshake: a pop frees a slot for a same-cycle push when full
    always_comb begin
        full_s = (fifo_level == LVL_FULL);
        pop_s  = (state_r == ST_IDLE) && (fifo_level != LVL_EMPTY);
        push_s = key_data_stb && (!full_s || pop_s);
        drop_s = key_data_stb && full_s && !pop_s;
    end

    // FIFO storage, no reset needed since occupancy governs validity
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {key_broken, key_data};
        end
    end

    // FIFO pointers, occupancy, popped-entry register and overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_level <= LVL_EMPTY;
            pop_data_r <= 9'd0;
            overflow   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r   <= rd_ptr_r + PTR_W'(1);
                // read now: a same-edge push into a full FIFO reuses this slot
                pop_data_r <= mem_r[rd_ptr_r];
            end
            case ({push_s, pop_s})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
            if (drop_s) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    // Consumer FSM next-state
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fifo_level != LVL_EMPTY) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FETCH: next_state_s = ST_APPLY;
            ST_APPLY: next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Effect of the captured event when the FSM is in APPLY
    always_comb begin
        acc_next_s    = acc_r;
        disp_next_s   = display_value;
        cnt_next_s    = digit_count;
        commit_next_s = commit_value;
        commit_fire_s = 1'b0;
        hex_s         = hex_decode(entry_r[7:0]);
        if (state_r == ST_APPLY) begin
            if (mode) begin
                disp_next_s = {{(DISP_W-9){1'b0}}, entry_r};
            end else if (entry_r[8]) begin
                disp_next_s = display_value;
            end else begin
                if (hex_s[4]) begin
                    acc_next_s = {acc_r[DISP_W-5:0], hex_s[3:0]};
                    cnt_next_s = (digit_count == CNT_MAX) ? CNT_MAX : digit_count + 4'd1;
                end else begin
                    case (entry_r[7:0])
                        8'h08: begin
                            acc_next_s = acc_r >> 3'd4;
                            cnt_next_s = (digit_count == 4'd0) ? 4'd0 : digit_count - 4'd1;
                        end
                        8'h1B: begin
                            acc_next_s = {DISP_W{1'b0}};
                            cnt_next_s = 4'd0;
                        end
                        8'h0D: begin
                            commit_next_s = acc_r;
                            commit_fire_s = 1'b1;
                            acc_next_s    = {DISP_W{1'b0}};
                            cnt_next_s    = 4'd0;
                        end
                        default: acc_next_s = acc_r;
                    endcase
                end
                disp_next_s = acc_next_s;
            end
        end else begin
            commit_fire_s = 1'b0;
        end
    end

    // FSM state, captured entry and registered entry results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            entry_r       <= 9'd0;
            acc_r         <= {DISP_W{1'b0}};
            display_value <= {DISP_W{1'b0}};
            digit_count   <= 4'd0;
            commit_value  <= {DISP_W{1'b0}};
            commit_stb    <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (state_r == ST_FETCH) begin
                entry_r <= pop_data_r;
            end
            acc_r         <= acc_next_s;
            display_value <= disp_next_s;
            digit_count   <= cnt_next_s;
            commit_value  <= commit_next_s;
            commit_stb    <= commit_fire_s;
        end
    end

    key_hex_entry_chk #(
        .DIGITS     (DIGITS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .LVL_W      (LVL_W)
    ) u_chk (
        .clk            (clk),
        .rst            (rst),
        .clear_overflow (clear_overflow),
        .commit_stb     (commit_stb),
        .overflow       (overflow),
        .digit_count    (digit_count),
        .fifo_level     (fifo_level)
    );

endmodule

// Invariants of the entry engine's outputs.
module key_hex_entry_chk #(
    parameter int DIGITS     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input logic             clk,
    input logic             rst,
    input logic             clear_overflow,
    input logic             commit_stb,
    input logic             overflow,
    input logic [3:0]       digit_count,
    input logic [LVL_W-1:0] fifo_level
);

    a_stb_single: assert property (@(posedge clk) disable iff (rst)
        commit_stb |=> !commit_stb);

    a_digits_max: assert property (@(posedge clk) disable iff (rst)
        digit_count <= 4'(DIGITS));

    a_level_max: assert property (@(posedge clk) disable iff (rst)
        fifo_level <= LVL_W'(FIFO_DEPTH));

    a_ovf_sticky: assert property (@(posedge clk) disable iff (rst)
        (overflow && !clear_overflow) |=> overflow);

endmodule
